// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel valid/ready mux with fixed-select or round-robin arbitration and a one-word output register
module arb_mux_n #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hi_any, lo_any, fix_any, any, can_load, xfer;
  logic [SEL_W-1:0] hi_g, lo_g, g;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0] sel_data;
  // pick winner: round-robin prefers lowest index above rr_ptr, else lowest at/below it
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    fix_any = 1'b0;
    hi_g = '0;
    lo_g = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i] && SEL_W'(i) > rr_ptr_q) begin
        hi_any = 1'b1;
        hi_g = SEL_W'(i);
      end
      if (in_valid[i] && SEL_W'(i) <= rr_ptr_q) begin
        lo_any = 1'b1;
        lo_g = SEL_W'(i);
      end
      if (in_valid[i] && sel == SEL_W'(i)) fix_any = 1'b1;
    end
    any = mode ? (hi_any | lo_any) : fix_any;
    g = mode ? (hi_any ? hi_g : lo_g) : sel;
  end
  // one-hot grant and data select; an out-of-range sel matches no channel
  always_comb begin
    grant = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g == SEL_W'(i)) begin
        grant[i] = any;
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end
  assign can_load = ~out_valid_q | out_ready;
  assign in_ready = grant & {NUM_CH{can_load & ~rst}};
  assign xfer = any & can_load & ~rst;
  // load on transfer, drain on consumer accept, otherwise hold
  always_comb begin
    out_valid_d = xfer | (out_valid_q & ~out_ready);
    out_data_d = xfer ? sel_data : out_data_q;
    out_ch_d = xfer ? g : out_ch_q;
    rr_ptr_d = (xfer & mode) ? g : rr_ptr_q;
  end
  // output register and round-robin pointer; reset points at last channel so ch0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      rr_ptr_q <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: directed and randomized checks of arb_mux_n against a queue-free behavioural model
module tb_arb_mux_n;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, mode, out_ready, out_valid;
  logic [1:0] sel, out_ch;
  logic [N-1:0] in_valid, in_ready;
  logic [N*8-1:0] in_data;
  logic [7:0] out_data;
  logic mode3, out_ready3, out_valid3;
  logic [1:0] sel3, out_ch3;
  logic [2:0] in_valid3, in_ready3;
  logic [47:0] in_data3;
  logic [15:0] out_data3;
  int checks = 0;
  int errors = 0;
  bit m_v;
  int m_d, m_ch, m_ptr;
  int exp_seq[5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;
  arb_mux_n dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );
  arb_mux_n #(.WIDTH(16), .NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int model_grant();
    int c;
    if (rst) return -1;
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction
  task automatic cyc();
    int g;
    int exp_rdy;
    g = model_grant();
    exp_rdy = (g >= 0 && (!m_v || out_ready)) ? (1 << g) : 0;
    #1;
    chk("in_ready", 32'(in_ready), exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_d = 0; m_ch = 0; m_ptr = N - 1;
    end else if (exp_rdy != 0) begin
      m_v = 1; m_d = int'(in_data[g*8 +: 8]); m_ch = g;
      if (mode) m_ptr = g;
    end else if (out_ready) m_v = 0;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("out_data", 32'(out_data), m_d);
    chk("out_ch", 32'(out_ch), m_ch);
  endtask
  initial begin
    rst = 1; mode = 1; sel = 0; out_ready = 1; in_valid = 4'hF; in_data = 32'h44332211;
    mode3 = 0; sel3 = 0; out_ready3 = 1; in_valid3 = 0; in_data3 = 0;
    m_v = 0; m_d = 0; m_ch = 0; m_ptr = N - 1;
    @(posedge clk); #1;
    cyc();
    cyc();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ready", 32'(in_ready), 0);
    rst = 0;
    cyc();
    chk("first_rr_ch", 32'(out_ch), 0);
    chk("first_rr_data", 32'(out_data), 32'h11);
    mode = 0; sel = 2; in_valid = 4'b0111; in_data = 32'h00A50000;
    cyc();
    chk("fixed_data", 32'(out_data), 32'hA5);
    chk("fixed_ch", 32'(out_ch), 2);
    rst = 1;
    cyc();
    rst = 0; mode = 1; in_valid = 4'hF; in_data = 32'h13121110;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_seq_ch", 32'(out_ch), exp_seq[i]);
      chk("rr_seq_valid", 32'(out_valid), 1);
      chk("rr_seq_data", 32'(out_data), 32'h10 + exp_seq[i]);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_sparse_ch", 32'(out_ch), (i % 2 == 0) ? 1 : 3);
    end
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_data", 32'(out_data), 32'h13);
      chk("stall_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    cyc();
    chk("unstall_ch", 32'(out_ch), 1);
    chk("unstall_valid", 32'(out_valid), 1);
    rst = 1;
    cyc();
    chk("midrst_valid", 32'(out_valid), 0);
    rst = 0; in_valid = 4'hF;
    cyc();
    chk("rr_restart_ch", 32'(out_ch), 0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(31) == 0);
      mode = 1'($urandom_range(1));
      sel = 2'($urandom_range(3));
      in_valid = 4'($urandom_range(15));
      in_data = $urandom;
      out_ready = ($urandom_range(3) != 0);
      cyc();
    end
    rst = 0;
    mode3 = 0; sel3 = 3; in_valid3 = 3'b111; in_data3 = 48'h3333_2222_1111; out_ready3 = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("n3_oob_ready", 32'(in_ready3), 0);
      @(posedge clk); #1;
      chk("n3_oob_valid", 32'(out_valid3), 0);
    end
    sel3 = 1;
    #1;
    chk("n3_ready", 32'(in_ready3), 3'b010);
    @(posedge clk); #1;
    chk("n3_valid", 32'(out_valid3), 1);
    chk("n3_data", 32'(out_data3), 32'h2222);
    chk("n3_ch", 32'(out_ch3), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
